// File: rtl/note_highway_pkg.sv
// note_highway_pkg: shared definitions for the note highway peripheral.
//   - lane count and lane-mask type
//   - register word addresses
//   - STATUS register field offsets
//   - popcount helper used for miss accounting
package note_highway_pkg;

  // Lane count is tied to the width of the processor's buttons/intersections.
  localparam int unsigned LANES      = 4;
  localparam int unsigned LANE_CNT_W = $clog2(LANES + 1);

  typedef logic [LANES-1:0] lane_mask_t;

  // Register word addresses
  localparam logic [2:0] ADDR_PUSH   = 3'd0;
  localparam logic [2:0] ADDR_STATUS = 3'd1;
  localparam logic [2:0] ADDR_MISS   = 3'd2;
  localparam logic [2:0] ADDR_CTRL   = 3'd3;
  localparam logic [2:0] ADDR_DIV    = 3'd4;

  // STATUS field offsets
  localparam int unsigned ST_INT_LSB   = 0;
  localparam int unsigned ST_CNT_LSB   = 8;
  localparam int unsigned ST_CNT_W     = 4;
  localparam int unsigned ST_FULL_BIT  = 16;
  localparam int unsigned ST_EMPTY_BIT = 17;
  localparam int unsigned ST_OVF_BIT   = 18;

  function automatic logic [LANE_CNT_W-1:0] popcount(lane_mask_t m);
    logic [LANE_CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < LANES; i++) begin
      c = c + LANE_CNT_W'(m[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/note_highway_if.sv
// note_highway_if: dmem-style register bus between the processor and the note highway.
//   address : word address of the accessed register
//   wdata   : store data
//   wren    : store strobe, one write per cycle
//   rdata   : load data, registered one cycle after the address
// master = processor side, slave = peripheral side.
interface note_highway_if;
  logic [2:0]  address;
  logic [31:0] wdata;
  logic        wren;
  logic [31:0] rdata;

  modport master (
    output address,
    output wdata,
    output wren,
    input  rdata
  );

  modport slave (
    input  address,
    input  wdata,
    input  wren,
    output rdata
  );
endinterface

// File: rtl/note_fifo.sv
// note_fifo: synchronous chart FIFO holding lane masks.
//   clock   : rising-edge clock
//   reset   : asynchronous active-low, clears pointers and count
//   push_i  : enqueue data_i; accepted when not full, or when full with a pop this cycle
//   data_i  : lane mask to enqueue
//   pop_i   : dequeue request; ignored when empty
//   head_o  : oldest entry (valid when not empty)
//   full_o  : FIFO holds Depth entries
//   empty_o : FIFO holds no entries
//   count_o : number of stored entries
module note_fifo
  import note_highway_pkg::*;
#(
  parameter int unsigned Depth = 8,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            push_i,
  input  lane_mask_t      data_i,
  input  logic            pop_i,
  output lane_mask_t      head_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [CntW-1:0] count_o
);

  lane_mask_t      mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(Depth));
  assign pop_ok  = pop_i && !empty_o;
  // A pop in the same cycle frees a slot, so a push while full still lands.
  assign push_ok = push_i && (!full_o || pop_ok);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + 1'b1;
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/note_highway.sv
// note_highway: memory-mapped note highway feeding the Guitar Hero processor's intersections.
//   clock         : master clock, rising edge
//   reset         : asynchronous active-low, clears all state
//   bus           : register bus (slave side): address, wdata, wren in; rdata out (registered)
//   gameclk       : asynchronous game tick source, synchronized internally
//   hit_lanes     : single-cycle hit pulses per lane
//   intersections : per-lane OR of occupied hit-window rows (registered)
//   miss_pulse    : one-cycle pulse when a note leaves the bottom unhit
//   fifo_full     : chart FIFO is full
// Register map: 0 PUSH (wo), 1 STATUS, 2 MISS (ro, write clears), 3 CTRL (bit0 run), 4 DIV.
// Optional macro NOTE_HIGHWAY_DIV_EN: enables the 8-bit DIV register at address 4, so a tick
// fires on every (DIV+1)-th qualified gameclk edge. Without it every qualified edge ticks and
// address 4 reads 0.
module note_highway
  import note_highway_pkg::*;
#(
  parameter int unsigned HEIGHT     = 16,
  parameter int unsigned WIN        = 2,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned MISS_W     = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  note_highway_if.slave        bus,
  input  logic                 gameclk,
  input  lane_mask_t           hit_lanes,
  output lane_mask_t           intersections,
  output logic                 miss_pulse,
  output logic                 fifo_full
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  // Register decode
  logic wr_push, wr_status, wr_miss, wr_ctrl;
  assign wr_push   = bus.wren && (bus.address == ADDR_PUSH);
  assign wr_status = bus.wren && (bus.address == ADDR_STATUS);
  assign wr_miss   = bus.wren && (bus.address == ADDR_MISS);
  assign wr_ctrl   = bus.wren && (bus.address == ADDR_CTRL);

  logic unused_wdata;
  assign unused_wdata = ^bus.wdata;

  // State
  lane_mask_t [HEIGHT-1:0] rows_q, rows_d, hit_rows;
  lane_mask_t              intersections_q, win_or;
  logic                    miss_pulse_q;
  logic [MISS_W-1:0]       miss_q, miss_d;
  logic                    ovf_q, ovf_d;
  logic                    run_q, run_d;
  logic [31:0]             rdata_q, rdata_d;
  logic [2:0]              gsync_q;

  // gameclk: two synchronizer flops, then a delayed copy for rising-edge detection.
  logic game_edge, qual_edge, tick;
  assign game_edge = gsync_q[1] && !gsync_q[2];
  assign qual_edge = game_edge && run_q;

  logic [31:0] div_rd;
`ifdef NOTE_HIGHWAY_DIV_EN
  logic       wr_div;
  logic [7:0] div_q, div_cnt_q;

  assign wr_div = bus.wren && (bus.address == ADDR_DIV);
  assign tick   = qual_edge && (div_cnt_q == div_q);
  assign div_rd = 32'(div_q);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_q     <= '0;
      div_cnt_q <= '0;
    end else if (wr_div) begin
      div_q     <= bus.wdata[7:0];
      div_cnt_q <= '0;
    end else if (qual_edge) begin
      div_cnt_q <= tick ? 8'd0 : div_cnt_q + 8'd1;
    end
  end
`else
  assign tick   = qual_edge;
  assign div_rd = '0;
`endif

  // Chart FIFO; a tick pops the head into row 0.
  lane_mask_t      fifo_head;
  logic            fifo_empty, fifo_full_w;
  logic [CntW-1:0] fifo_count;

  note_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (wr_push),
    .data_i  (bus.wdata[LANES-1:0]),
    .pop_i   (tick),
    .head_o  (fifo_head),
    .full_o  (fifo_full_w),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Hits clear the most advanced (highest-index) occupied window row of each lane.
  lane_mask_t hit_done;
  always_comb begin
    hit_rows = rows_q;
    hit_done = '0;
    for (int r = int'(HEIGHT) - 1; r >= int'(HEIGHT - WIN); r--) begin
      for (int l = 0; l < int'(LANES); l++) begin
        if (hit_lanes[l] && !hit_done[l] && rows_q[r][l]) begin
          hit_rows[r][l] = 1'b0;
          hit_done[l]    = 1'b1;
        end
      end
    end
  end

  // Scroll after hits; whatever remains in the bottom row falls off as misses.
  lane_mask_t leaving;
  always_comb begin
    rows_d  = hit_rows;
    leaving = '0;
    if (tick) begin
      leaving = hit_rows[HEIGHT-1];
      for (int r = int'(HEIGHT) - 1; r >= 1; r--) begin
        rows_d[r] = hit_rows[r-1];
      end
      rows_d[0] = fifo_empty ? '0 : fifo_head;
    end
  end

  always_comb begin
    win_or = '0;
    for (int r = int'(HEIGHT - WIN); r < int'(HEIGHT); r++) begin
      win_or = win_or | rows_d[r];
    end
  end

  // Saturating miss counter; a MISS write wins over a same-cycle increment.
  logic [MISS_W:0] miss_sum;
  assign miss_sum = {1'b0, miss_q} + (MISS_W + 1)'(popcount(leaving));

  always_comb begin
    miss_d = miss_q;
    if (wr_miss) begin
      miss_d = '0;
    end else if (|leaving) begin
      miss_d = miss_sum[MISS_W] ? '1 : miss_sum[MISS_W-1:0];
    end
  end

  // Overflow: push dropped because the FIFO is full and nothing pops this cycle.
  always_comb begin
    ovf_d = ovf_q;
    if (wr_push && fifo_full_w && !(tick && !fifo_empty)) begin
      ovf_d = 1'b1;
    end
    if (wr_status && bus.wdata[ST_OVF_BIT]) begin
      ovf_d = 1'b0;
    end
  end

  always_comb begin
    run_d = run_q;
    if (wr_ctrl) run_d = bus.wdata[0];
  end

  // Read mux, captured into rdata at the next edge.
  logic [31:0] status_word;
  always_comb begin
    status_word                            = '0;
    status_word[ST_INT_LSB +: LANES]       = intersections_q;
    status_word[ST_CNT_LSB +: ST_CNT_W]    = ST_CNT_W'(fifo_count);
    status_word[ST_FULL_BIT]               = fifo_full_w;
    status_word[ST_EMPTY_BIT]              = fifo_empty;
    status_word[ST_OVF_BIT]                = ovf_q;
  end

  always_comb begin
    rdata_d = '0;
    unique case (bus.address)
      ADDR_STATUS: rdata_d = status_word;
      ADDR_MISS:   rdata_d = 32'(miss_q);
      ADDR_CTRL:   rdata_d = {31'b0, run_q};
      ADDR_DIV:    rdata_d = div_rd;
      default:     rdata_d = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rows_q          <= '0;
      intersections_q <= '0;
      miss_pulse_q    <= 1'b0;
      miss_q          <= '0;
      ovf_q           <= 1'b0;
      run_q           <= 1'b0;
      rdata_q         <= '0;
      gsync_q         <= '0;
    end else begin
      rows_q          <= rows_d;
      intersections_q <= win_or;
      miss_pulse_q    <= |leaving;
      miss_q          <= miss_d;
      ovf_q           <= ovf_d;
      run_q           <= run_d;
      rdata_q         <= rdata_d;
      gsync_q         <= {gsync_q[1:0], gameclk};
    end
  end

  assign bus.rdata     = rdata_q;
  assign intersections = intersections_q;
  assign miss_pulse    = miss_pulse_q;
  assign fifo_full     = fifo_full_w;

endmodule

// File: doc/note_highway.md
Name: note_highway

Overview:
- Memory-mapped peripheral that drives the `intersections` input of the Guitar Hero processor; it is the producer side of that interface.
- The processor pushes chart entries (4-bit lane masks) through dmem-style stores.
- Each game tick, the block scrolls notes down a HEIGHT-row highway per lane.
- It flags lanes whose hit window is occupied, clears notes on hits, and counts misses.

Parameters:
- LANES, 4, number of lanes; fixed to the width of buttons/intersections.
- HEIGHT, 16, rows per lane; row 0 is the top, row HEIGHT-1 is the bottom.
- WIN, 2, hit-window rows: HEIGHT-WIN through HEIGHT-1.
- FIFO_DEPTH, 8, chart FIFO entries; power of two.
- MISS_W, 16, miss counter width.

Ports:
- clock  in  1  master clock, rising-edge.
- reset  in  1  asynchronous, active-low; clears all state.
- address  in  3  word address of the register being accessed.
- wdata  in  32  store data.
- wren  in  1  store strobe; one write per cycle.
- rdata  out  32  load data, registered.
- gameclk  in  1  asynchronous game tick source.
- hit_lanes  in  LANES  single-cycle hit pulses per lane, from strum/button logic.
- intersections  out  LANES  per-lane OR of occupied window rows.
- miss_pulse  out  1  one-cycle pulse when at least one note leaves the bottom unhit.
- fifo_full  out  1  chart FIFO full.

Behaviour:
- Reset (reset=0, async) sets all of the following to 0: rows, FIFO pointers/count, overflow flag, miss count, run, rdata, intersections, miss_pulse, fifo_full. After reset, DIV=0.
- Register map:
  - 0 PUSH, write-only: wdata[3:0] is the lane mask, pushed to the FIFO.
  - 1 STATUS: [3:0] intersections, [11:8] fifo count, [16] full, [17] empty, [18] overflow (sticky). Writing bit18=1 clears overflow.
  - 2 MISS, read-only count, zero-extended. Any write clears it.
  - 3 CTRL: bit0 run.
  - 4 DIV: see Optional Feature.
  - Reads of unmapped addresses return 0. Writes to unmapped addresses are ignored.
- Read latency is 1 cycle: rdata is registered from the address presented in the previous cycle.
- Tick generation:
  - gameclk passes through a 2-flop synchronizer followed by a rising-edge detector.
  - tick = edge AND run.
  - Latency from a gameclk rise to the first tick is 3 clocks.
- On a tick, in this order:
  - Apply hit_lanes to the pre-shift state.
  - Shift every lane down one row.
  - Bottom rows that are still occupied: miss count += popcount of those lanes, saturating at 2^MISS_W-1. miss_pulse=1 for that cycle.
  - Row 0 is loaded from the FIFO head, which is popped if the FIFO is non-empty; otherwise row 0 is loaded with 0.
- Hit, with or without a tick: hit_lanes[l] clears the lowest occupied window row in lane l, i.e. the most advanced note. It does nothing if the window is empty.
- intersections is registered and reflects the row state after the cycle's update.
- FIFO:
  - A push while full is dropped and sets overflow, unless a pop occurs in the same cycle, in which case the push is accepted.
  - A push while empty on a tick cycle is not bypassed; the entry enters row 0 on the next tick.
  - Mask 0 is a legal entry and produces an empty row.
- Clearing run stops scrolling; hits still apply.
- A MISS write coinciding with a miss increment: the clear wins, and miss_pulse still fires.
- Reset in mid-game returns the block to idle within the same cycle, asynchronously.

Optional Feature:
- Macro: NOTE_HIGHWAY_DIV_EN.
- When defined:
  - Address 4 is the DIV register, 8 bits, read/write.
  - A tick fires only on every (DIV+1)-th qualified gameclk edge.
  - The divider counter resets when DIV is written.
- When undefined:
  - Every qualified edge ticks.
  - Address 4 reads 0 and writes to it are ignored.

Decomposition:
- Shared package note_highway_pkg holds:
  - Address constants ADDR_PUSH, ADDR_STATUS, ADDR_MISS, ADDR_CTRL, ADDR_DIV.
  - STATUS bit offsets.
  - The lane-mask typedef.
- One sub-module, note_fifo: a synchronous FIFO with push, pop, full, empty and count, storing LANES-bit entries. It is instantiated once.

Test Plan:
- Reset, run=1, push 4'b0101, then 15 ticks → intersections=0101 after tick 15 (row HEIGHT-1 at WIN=2 is reached on tick 16, and row 14 is inside the window after tick 15). One more tick without a hit, then a second tick → MISS=2, miss_pulse asserted for one cycle.
- Push 4'b0001 and tick until intersections=0001, then pulse hit_lanes=0001 → intersections=0000, no miss ever counted, MISS=0.
- Push 9 entries into an empty FIFO with no tick → fifo_full=1, STATUS[18]=1, count=8. Write STATUS with bit18=1 → overflow=0.
- With the FIFO full, a push in the same cycle as a tick → push accepted, count stays 8, overflow stays 0.
- hit_lanes=0010 in the same cycle as the tick that would push a lane-1 note off the bottom → note cleared, MISS unchanged.
- With NOTE_HIGHWAY_DIV_EN defined and DIV=2: 6 gameclk rises → exactly 2 ticks. Assert reset low mid-sequence → all outputs 0 immediately.
